// File: rtl/mac_package.sv
// Shared constants and types for the MAC streamer TCDM blocks.
package mac_package;

  localparam int MAC_TCDM_MUX_NCH_DEFAULT = 4;
  // Wide enough for any MAX_OUT in use; the mux narrows it to its own port width.
  localparam int MAC_TCDM_MUX_CNT_W = 8;

  typedef struct packed {
    logic [MAC_TCDM_MUX_CNT_W-1:0] outstanding;
    logic                          busy;
    logic                          err;
  } flags_tcdm_mux_t;

endpackage

// File: rtl/mac_streamer_tcdm_mux_id_fifo.sv
// In-order queue of channel IDs for outstanding reads. Push is ignored when full,
// pop is ignored when empty.
module mac_streamer_tcdm_mux_id_fifo #(
  parameter  int IW    = 2,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [IW-1:0] id_i,
  input  logic          pop_i,
  output logic [IW-1:0] id_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [PW:0]   occ_o
);

  logic [DEPTH-1:0][IW-1:0] mem;
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [PW:0]              cnt;
  logic                     push_en, pop_en;

  assign full_o  = (cnt == (PW+1)'(DEPTH));
  assign empty_o = (cnt == '0);
  assign occ_o   = cnt;
  assign id_o    = mem[rd_ptr];
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_en, pop_en})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem[wr_ptr] <= id_i;
  end

endmodule

// File: rtl/mac_streamer_tcdm_mux.sv
// Round-robin concentrator of NCH streamer TCDM channels onto one TCDM port.
// Define MAC_STREAMER_TCDM_MUX_STORE_PRIO_EN to give channel NCH-1 strict priority.
module mac_streamer_tcdm_mux
  import mac_package::*;
#(
  parameter  int NCH     = MAC_TCDM_MUX_NCH_DEFAULT,
  parameter  int DW      = 32,
  parameter  int AW      = 32,
  parameter  int MAX_OUT = 4,
  localparam int IW      = $clog2(NCH),
  localparam int OW      = $clog2(MAX_OUT) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic [NCH-1:0]    ch_req_i,
  output logic [NCH-1:0]    ch_gnt_o,
  input  logic [NCH*AW-1:0] ch_add_i,
  input  logic [NCH-1:0]    ch_wen_i,
  input  logic [NCH*DW/8-1:0] ch_be_i,
  input  logic [NCH*DW-1:0] ch_data_i,
  output logic [DW-1:0]     ch_r_data_o,
  output logic [NCH-1:0]    ch_r_valid_o,
  output logic              tcdm_req_o,
  input  logic              tcdm_gnt_i,
  output logic [AW-1:0]     tcdm_add_o,
  output logic              tcdm_wen_o,
  output logic [DW/8-1:0]   tcdm_be_o,
  output logic [DW-1:0]     tcdm_data_o,
  input  logic [DW-1:0]     tcdm_r_data_i,
  input  logic              tcdm_r_valid_i,
  output logic [OW-1:0]     outstanding_o,
  output logic              busy_o,
  output logic              err_o
);

  logic            srst;
  logic [IW-1:0]   rr_ptr, winner, id_head;
  logic            win_rd, allow, hs, push, pop, rr_upd, err_q;
  logic            id_full, id_empty;
  logic [OW-1:0]   id_occ;
  flags_tcdm_mux_t flags;
  logic            unused_flags;

  assign srst = rst_i | clear_i;

  // Reverse scan so the lowest offset from rr_ptr is assigned last and wins.
  always_comb begin
    winner = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (ch_req_i[(int'(rr_ptr) + i) % NCH]) winner = IW'((int'(rr_ptr) + i) % NCH);
    end
`ifdef MAC_STREAMER_TCDM_MUX_STORE_PRIO_EN
    if (ch_req_i[NCH-1]) winner = IW'(NCH-1);
`endif
  end

  assign win_rd     = ch_wen_i[winner];
  assign allow      = ~(win_rd & id_full);
  assign tcdm_req_o = ~srst & enable_i & (|ch_req_i) & allow;
  assign hs         = tcdm_req_o & tcdm_gnt_i;
  assign push       = hs & win_rd;
  assign ch_gnt_o   = hs ? (NCH'(1) << winner) : '0;

  assign tcdm_add_o  = srst ? '0 : ch_add_i[int'(winner)*AW +: AW];
  assign tcdm_wen_o  = srst ? 1'b0 : win_rd;
  assign tcdm_be_o   = srst ? '0 : ch_be_i[int'(winner)*(DW/8) +: DW/8];
  assign tcdm_data_o = srst ? '0 : ch_data_i[int'(winner)*DW +: DW];

  // Responses are routed combinationally to the oldest outstanding reader.
  assign pop          = ~srst & tcdm_r_valid_i & ~id_empty;
  assign ch_r_valid_o = pop ? (NCH'(1) << id_head) : '0;
  assign ch_r_data_o  = srst ? '0 : tcdm_r_data_i;

`ifdef MAC_STREAMER_TCDM_MUX_STORE_PRIO_EN
  assign rr_upd = hs & ~ch_req_i[NCH-1];
`else
  assign rr_upd = hs;
`endif

  always_ff @(posedge clk_i) begin
    if (srst) begin
      rr_ptr <= '0;
      err_q  <= 1'b0;
    end else begin
      if (rr_upd) rr_ptr <= (winner == IW'(NCH-1)) ? '0 : winner + IW'(1);
      if (tcdm_r_valid_i & id_empty) err_q <= 1'b1;
    end
  end

  mac_streamer_tcdm_mux_id_fifo #(
    .IW    (IW),
    .DEPTH (MAX_OUT)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (srst),
    .push_i  (push),
    .id_i    (winner),
    .pop_i   (pop),
    .id_o    (id_head),
    .full_o  (id_full),
    .empty_o (id_empty),
    .occ_o   (id_occ)
  );

  always_comb begin
    flags             = '0;
    flags.outstanding = srst ? '0 : MAC_TCDM_MUX_CNT_W'(id_occ);
    flags.busy        = ~srst & ((|ch_req_i) | (id_occ != '0));
    flags.err         = ~srst & err_q;
  end

  assign outstanding_o = OW'(flags.outstanding);
  assign busy_o        = flags.busy;
  assign err_o         = flags.err;
  assign unused_flags  = ^flags;

endmodule

// File: tb/tb_mac_streamer_tcdm_mux.sv
// Directed bench for mac_streamer_tcdm_mux: vector table plus hand sequences.
module tb_mac_streamer_tcdm_mux;

  localparam int NCH = 4, DW = 32, AW = 32, MAX_OUT = 4, OW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clear, enable;
  logic [NCH-1:0] ch_req, ch_gnt, ch_wen, ch_r_valid;
  logic [NCH*AW-1:0] ch_add;
  logic [NCH*DW/8-1:0] ch_be;
  logic [NCH*DW-1:0] ch_data;
  logic [DW-1:0] ch_r_data, tcdm_data, tcdm_r_data;
  logic tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid, busy, err;
  logic [AW-1:0] tcdm_add;
  logic [DW/8-1:0] tcdm_be;
  logic [OW-1:0] outstanding;

  mac_streamer_tcdm_mux #(.NCH(NCH), .DW(DW), .AW(AW), .MAX_OUT(MAX_OUT)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(enable),
    .ch_req_i(ch_req), .ch_gnt_o(ch_gnt), .ch_add_i(ch_add), .ch_wen_i(ch_wen),
    .ch_be_i(ch_be), .ch_data_i(ch_data), .ch_r_data_o(ch_r_data), .ch_r_valid_o(ch_r_valid),
    .tcdm_req_o(tcdm_req), .tcdm_gnt_i(tcdm_gnt), .tcdm_add_o(tcdm_add), .tcdm_wen_o(tcdm_wen),
    .tcdm_be_o(tcdm_be), .tcdm_data_o(tcdm_data), .tcdm_r_data_i(tcdm_r_data),
    .tcdm_r_valid_i(tcdm_r_valid), .outstanding_o(outstanding), .busy_o(busy), .err_o(err)
  );

  typedef struct {
    logic [3:0] req, wen;
    logic       gnt, rv, ereq;
    logic [3:0] egnt;
    int         ewin;
    logic [3:0] erv;
    int         eocc;
    logic       eerr;
  } vec_t;

  vec_t tbl[$];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] wen, input logic gnt,
                              input logic rv, input logic ereq, input logic [3:0] egnt,
                              input int ewin, input logic [3:0] erv, input int eocc,
                              input logic eerr);
    vec_t v;
    v.req = req; v.wen = wen; v.gnt = gnt; v.rv = rv; v.ereq = ereq; v.egnt = egnt;
    v.ewin = ewin; v.erv = erv; v.eocc = eocc; v.eerr = eerr;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    logic [31:0] rd;
    rst = 1'b1; clear = 1'b0; enable = 1'b1;
    ch_req = 4'hF; ch_wen = 4'hF; tcdm_gnt = 1'b1; tcdm_r_valid = 1'b1;
    tcdm_r_data = 32'hDEAD_BEEF;
    for (int k = 0; k < NCH; k++) begin
      ch_add[k*AW +: AW]         = 32'h100 * (k + 1);
      ch_data[k*DW +: DW]        = 32'hD000_0000 | k;
      ch_be[k*(DW/8) +: (DW/8)]  = 4'(k + 1);
    end

    // Everything reads as zero while reset is held, even with live inputs.
    tick(); tick();
    chk("rst tcdm_req", 32'(tcdm_req), 0);
    chk("rst gnt", 32'(ch_gnt), 0);
    chk("rst add", tcdm_add, 0);
    chk("rst r_data", ch_r_data, 0);
    chk("rst r_valid", 32'(ch_r_valid), 0);
    chk("rst outstanding", 32'(outstanding), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst err", 32'(err), 0);
    ch_req = '0; tcdm_r_valid = 1'b0;
    rst = 1'b0;
    tick();

`ifndef MAC_STREAMER_TCDM_MUX_STORE_PRIO_EN
    //             req  wen  g  rv ereq egnt win erv occ err
    tbl.push_back(mk(4'hF, 4'hF, 1, 0, 1, 4'h1, 0, 4'h0, 0, 0));
    tbl.push_back(mk(4'hF, 4'hF, 1, 1, 1, 4'h2, 1, 4'h1, 1, 0));
    tbl.push_back(mk(4'hF, 4'hF, 1, 1, 1, 4'h4, 2, 4'h2, 1, 0));
    tbl.push_back(mk(4'hF, 4'hF, 1, 1, 1, 4'h8, 3, 4'h4, 1, 0));
    tbl.push_back(mk(4'hF, 4'hF, 1, 1, 1, 4'h1, 0, 4'h8, 1, 0));
    tbl.push_back(mk(4'h2, 4'hF, 1, 1, 1, 4'h2, 1, 4'h1, 1, 0));
    tbl.push_back(mk(4'h8, 4'hF, 1, 1, 1, 4'h8, 3, 4'h2, 1, 0));
    tbl.push_back(mk(4'h0, 4'hF, 1, 1, 0, 4'h0, 0, 4'h8, 1, 0));
    for (int s = 0; s < 5; s++)
      tbl.push_back(mk(4'h5, 4'hF, 0, 0, 1, 4'h0, 0, 4'h0, 0, 0));
    tbl.push_back(mk(4'h5, 4'hF, 1, 0, 1, 4'h1, 0, 4'h0, 0, 0));
    tbl.push_back(mk(4'h5, 4'hF, 1, 0, 1, 4'h4, 2, 4'h0, 1, 0));
    tbl.push_back(mk(4'h0, 4'hF, 1, 1, 0, 4'h0, 0, 4'h1, 2, 0));
    tbl.push_back(mk(4'h0, 4'hF, 1, 1, 0, 4'h0, 0, 4'h4, 1, 0));
    tbl.push_back(mk(4'hF, 4'hF, 1, 0, 1, 4'h8, 3, 4'h0, 0, 0));
    tbl.push_back(mk(4'hF, 4'hF, 1, 0, 1, 4'h1, 0, 4'h0, 1, 0));
    tbl.push_back(mk(4'hF, 4'hF, 1, 0, 1, 4'h2, 1, 4'h0, 2, 0));
    tbl.push_back(mk(4'hF, 4'hF, 1, 0, 1, 4'h4, 2, 4'h0, 3, 0));
    tbl.push_back(mk(4'hF, 4'hF, 1, 0, 0, 4'h0, 3, 4'h0, 4, 0)); // full: read blocked
    tbl.push_back(mk(4'hF, 4'h7, 1, 0, 1, 4'h8, 3, 4'h0, 4, 0)); // write still passes
    tbl.push_back(mk(4'h0, 4'hF, 1, 1, 0, 4'h0, 0, 4'h8, 4, 0));
    tbl.push_back(mk(4'h0, 4'hF, 1, 1, 0, 4'h0, 0, 4'h1, 3, 0));
    tbl.push_back(mk(4'h0, 4'hF, 1, 1, 0, 4'h0, 0, 4'h2, 2, 0));
    tbl.push_back(mk(4'h0, 4'hF, 1, 1, 0, 4'h0, 0, 4'h4, 1, 0));
    tbl.push_back(mk(4'h0, 4'hF, 1, 1, 0, 4'h0, 0, 4'h0, 0, 0)); // stray response
    tbl.push_back(mk(4'h0, 4'hF, 0, 0, 0, 4'h0, 0, 4'h0, 0, 1));

    foreach (tbl[i]) begin
      rd = 32'hA000_0000 + i;
      ch_req = tbl[i].req; ch_wen = tbl[i].wen; tcdm_gnt = tbl[i].gnt;
      tcdm_r_valid = tbl[i].rv; tcdm_r_data = rd;
      #3;
      w = tbl[i].ewin;
      chk($sformatf("row%0d tcdm_req", i), 32'(tcdm_req), 32'(tbl[i].ereq));
      chk($sformatf("row%0d gnt", i), 32'(ch_gnt), 32'(tbl[i].egnt));
      chk($sformatf("row%0d add", i), tcdm_add, 32'h100 * (w + 1));
      chk($sformatf("row%0d wdata", i), tcdm_data, 32'hD000_0000 | w);
      chk($sformatf("row%0d be", i), 32'(tcdm_be), w + 1);
      chk($sformatf("row%0d wen", i), 32'(tcdm_wen), 32'(tbl[i].wen[w]));
      chk($sformatf("row%0d r_valid", i), 32'(ch_r_valid), 32'(tbl[i].erv));
      chk($sformatf("row%0d r_data", i), ch_r_data, rd);
      chk($sformatf("row%0d outstanding", i), 32'(outstanding), tbl[i].eocc);
      chk($sformatf("row%0d err", i), 32'(err), 32'(tbl[i].eerr));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'((tbl[i].req != 0) || (tbl[i].eocc != 0)));
      tick();
    end

    tick(); tick(); tick();
    #3 chk("err sticky", 32'(err), 1);
`endif

    // Clear with two reads in flight; their late responses must be dropped.
    ch_wen = 4'hF; tcdm_gnt = 1'b1; tcdm_r_valid = 1'b0;
    ch_req = 4'h1; tick();
    ch_req = 4'h2; tick();
    ch_req = 4'h0;
    #3 chk("pre-clear outstanding", 32'(outstanding), 2);
    tick();
    clear = 1'b1; ch_req = 4'h5; tcdm_r_valid = 1'b1;
    #3;
    chk("clear tcdm_req", 32'(tcdm_req), 0);
    chk("clear r_valid", 32'(ch_r_valid), 0);
    chk("clear busy", 32'(busy), 0);
    tick();
    clear = 1'b0; ch_req = 4'h0; tcdm_r_valid = 1'b0;
    #3;
    chk("post-clear outstanding", 32'(outstanding), 0);
    chk("post-clear err", 32'(err), 0);
    tick();
    tcdm_r_valid = 1'b1;
    #3 chk("late rv1 r_valid", 32'(ch_r_valid), 0);
    tick();
    #3 chk("late rv2 r_valid", 32'(ch_r_valid), 0);
    tick();
    tcdm_r_valid = 1'b0;
    #3 chk("late rv err", 32'(err), 1);
    tick();

    // enable low only gates new requests.
    enable = 1'b0; ch_req = 4'h1; ch_wen = 4'h0;
    #3;
    chk("disabled tcdm_req", 32'(tcdm_req), 0);
    chk("disabled gnt", 32'(ch_gnt), 0);
    tick();
    enable = 1'b1;
    #3 chk("enabled gnt", 32'(ch_gnt), 1);
    tick();

    // Store channel priority versus plain round-robin, from rr_ptr=1.
    ch_req = 4'h0; rst = 1'b1; tick();
    rst = 1'b0; ch_wen = 4'h0;
    ch_req = 4'h1; tick();
    ch_req = 4'hA;
`ifdef MAC_STREAMER_TCDM_MUX_STORE_PRIO_EN
    #3 chk("prio store gnt", 32'(ch_gnt), 32'h8);
    tick();
    ch_req = 4'h3;
    #3 chk("prio rr held gnt", 32'(ch_gnt), 32'h2);
`else
    #3 chk("rr ch1 gnt", 32'(ch_gnt), 32'h2);
    tick();
    ch_req = 4'h3;
    #3 chk("rr advanced gnt", 32'(ch_gnt), 32'h1);
`endif
    tick();
    ch_req = 4'h0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
